// File: rtl/ez_riscv_pkg.sv
// Shared RV32I ALU decode constants, op-flag/entry types and skid-buffer states.
// X_LENGTH sets the datapath width (default 32) and must match the ALU.
`ifndef X_LENGTH
`define X_LENGTH 32
`endif

package ez_riscv_pkg;

  localparam int XLEN_WIDTH = `X_LENGTH;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic add;
    logic subtract;
    logic bit_and;
    logic bit_or;
    logic bit_xor;
    logic shift_left_logical;
    logic shift_right_arithmetic;
    logic shift_right_logical;
  } alu_op_t;

  typedef struct packed {
    alu_op_t                ops;
    logic [XLEN_WIDTH-1:0]  operand_1;
    logic [XLEN_WIDTH-1:0]  operand_2;
    logic [4:0]             rd_addr;
    logic                   reg_write;
    logic                   illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_SKID
  } skid_state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I ALU decoder: instruction word to one-hot op flags,
// the operand-2 immediate and an illegal flag.
module alu_op_decoder
  import ez_riscv_pkg::*;
#(
  parameter int XLEN = XLEN_WIDTH
) (
  input  logic [31:0]     instruction,
  output alu_op_t         ops,
  output logic [XLEN-1:0] immediate,
  output logic            use_immediate,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_reg_fields;

  assign opcode = instruction[6:0];
  assign funct7 = instruction[31:25];
  assign funct3 = instruction[14:12];
  assign unused_reg_fields = ^{instruction[19:15], instruction[11:7]};

  always_comb begin
    ops           = '0;
    immediate     = '0;
    use_immediate = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        case ({funct7, funct3})
          {FUNCT7_BASE, FUNCT3_ADD_SUB}: ops.add                    = 1'b1;
          {FUNCT7_ALT,  FUNCT3_ADD_SUB}: ops.subtract               = 1'b1;
          {FUNCT7_BASE, FUNCT3_AND}:     ops.bit_and                = 1'b1;
          {FUNCT7_BASE, FUNCT3_OR}:      ops.bit_or                 = 1'b1;
          {FUNCT7_BASE, FUNCT3_XOR}:     ops.bit_xor                = 1'b1;
          {FUNCT7_BASE, FUNCT3_SLL}:     ops.shift_left_logical     = 1'b1;
          {FUNCT7_BASE, FUNCT3_SRL_SRA}: ops.shift_right_logical    = 1'b1;
          {FUNCT7_ALT,  FUNCT3_SRL_SRA}: ops.shift_right_arithmetic = 1'b1;
          default:                       illegal                    = 1'b1;
        endcase
      end
      OPCODE_OP_IMM: begin
        use_immediate = 1'b1;
        immediate     = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
        case (funct3)
          FUNCT3_ADD_SUB: ops.add     = 1'b1;
          FUNCT3_AND:     ops.bit_and = 1'b1;
          FUNCT3_OR:      ops.bit_or  = 1'b1;
          FUNCT3_XOR:     ops.bit_xor = 1'b1;
          FUNCT3_SLL: begin
            immediate = {{(XLEN-5){1'b0}}, instruction[24:20]};
            if (funct7 == FUNCT7_BASE) ops.shift_left_logical = 1'b1;
            else                       illegal                = 1'b1;
          end
          FUNCT3_SRL_SRA: begin
            immediate = {{(XLEN-5){1'b0}}, instruction[24:20]};
            if (funct7 == FUNCT7_BASE)     ops.shift_right_logical    = 1'b1;
            else if (funct7 == FUNCT7_ALT) ops.shift_right_arithmetic = 1'b1;
            else                           illegal                    = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal entries carry no flags and no operands downstream.
    if (illegal) begin
      ops           = '0;
      immediate     = '0;
      use_immediate = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-ALU issue stage with a 2-entry skid buffer and registered in_ready.
// Optional macro ALU_ISSUE_FORWARD_EN adds execute-stage result forwarding.
module alu_issue_stage
  import ez_riscv_pkg::*;
#(
  parameter int XLEN = XLEN_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FORWARD_EN
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_reg_write,
  input  logic [XLEN-1:0] ex_result,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic            operation_add,
  output logic            operation_subtract,
  output logic            operation_and,
  output logic            operation_or,
  output logic            operation_xor,
  output logic            operation_shift_left_logical,
  output logic            operation_shift_right_arithmetic,
  output logic            operation_shift_right_logical,
  output logic [XLEN-1:0] operand_1,
  output logic [XLEN-1:0] operand_2,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            illegal_instruction
);

  alu_op_t         dec_ops;
  logic [XLEN-1:0] dec_immediate;
  logic            dec_use_immediate;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  issue_entry_t    in_entry;
  issue_entry_t    main_entry;
  issue_entry_t    skid_entry;
  skid_state_t     state;
  skid_state_t     next_state;
  logic            accept;
  logic            emit;
  logic            load_main_from_in;
  logic            load_main_from_skid;
  logic            load_skid;

  alu_op_decoder #(.XLEN(XLEN)) u_decoder (
    .instruction   (instruction),
    .ops           (dec_ops),
    .immediate     (dec_immediate),
    .use_immediate (dec_use_immediate),
    .illegal       (dec_illegal)
  );

`ifdef ALU_ISSUE_FORWARD_EN
  // rs2 only forwards for R-type; for I-type those bits are immediate.
  logic forward_rs1;
  logic forward_rs2;
  assign forward_rs1 = ex_reg_write && (ex_rd_addr != 5'd0) && (ex_rd_addr == instruction[19:15]);
  assign forward_rs2 = ex_reg_write && (ex_rd_addr != 5'd0) && (ex_rd_addr == instruction[24:20])
                       && (instruction[6:0] == OPCODE_OP);
  assign rs1_value = forward_rs1 ? ex_result : rs1_data;
  assign rs2_value = forward_rs2 ? ex_result : rs2_data;
`else
  assign rs1_value = rs1_data;
  assign rs2_value = rs2_data;
`endif

  always_comb begin
    in_entry.ops       = dec_ops;
    in_entry.operand_1 = dec_illegal ? '0 : rs1_value;
    in_entry.operand_2 = dec_illegal ? '0 : (dec_use_immediate ? dec_immediate : rs2_value);
    in_entry.rd_addr   = instruction[11:7];
    in_entry.reg_write = !dec_illegal && (instruction[11:7] != 5'd0);
    in_entry.illegal   = dec_illegal;
  end

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != ST_SKID);
    end
  end

  // Flush wins over both handshakes; SKID never accepts since in_ready is low there.
  always_comb begin
    next_state          = state;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            next_state        = ST_MAIN;
            load_main_from_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (accept && !emit) begin
            next_state = ST_SKID;
            load_skid  = 1'b1;
          end else if (accept && emit) begin
            load_main_from_in = 1'b1;
          end else if (emit) begin
            next_state = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (emit) begin
            next_state          = ST_MAIN;
            load_main_from_skid = 1'b1;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_entry <= '0;
      skid_entry <= '0;
    end else begin
      if (load_main_from_in)        main_entry <= in_entry;
      else if (load_main_from_skid) main_entry <= skid_entry;
      if (load_skid)                skid_entry <= in_entry;
    end
  end

  assign operation_add                    = main_entry.ops.add;
  assign operation_subtract               = main_entry.ops.subtract;
  assign operation_and                    = main_entry.ops.bit_and;
  assign operation_or                     = main_entry.ops.bit_or;
  assign operation_xor                    = main_entry.ops.bit_xor;
  assign operation_shift_left_logical     = main_entry.ops.shift_left_logical;
  assign operation_shift_right_arithmetic = main_entry.ops.shift_right_arithmetic;
  assign operation_shift_right_logical    = main_entry.ops.shift_right_logical;
  assign operand_1                        = main_entry.operand_1;
  assign operand_2                        = main_entry.operand_2;
  assign rd_addr                          = main_entry.rd_addr;
  assign reg_write                        = main_entry.reg_write;
  assign illegal_instruction              = main_entry.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table plus scoreboard,
// with hand-written back-pressure, flush, reset and (optional) forwarding sequences.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [7:0]  ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        exp;
  } vec_t;

  localparam logic [7:0] F_ADD = 8'h80;
  localparam logic [7:0] F_SUB = 8'h40;
  localparam logic [7:0] F_AND = 8'h20;
  localparam logic [7:0] F_OR  = 8'h10;
  localparam logic [7:0] F_XOR = 8'h08;
  localparam logic [7:0] F_SLL = 8'h04;
  localparam logic [7:0] F_SRA = 8'h02;
  localparam logic [7:0] F_SRL = 8'h01;
  localparam int NVEC = 24;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic        op_add, op_sub, op_and, op_or, op_xor, op_sll, op_sra, op_srl;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        illegal_instruction;
`ifdef ALU_ISSUE_FORWARD_EN
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic [31:0] ex_result;
`endif

  exp_t actual;
  exp_t cur_exp;
  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_act;
  vec_t vecs[NVEC];
  int   checks  = 0;
  int   errors  = 0;
  int   emitted = 0;
  int   cycles  = 0;

  alu_issue_stage dut (
    .clk                              (clk),
    .rst                              (rst),
    .flush                            (flush),
    .in_valid                         (in_valid),
    .in_ready                         (in_ready),
    .instruction                      (instruction),
    .rs1_data                         (rs1_data),
    .rs2_data                         (rs2_data),
`ifdef ALU_ISSUE_FORWARD_EN
    .ex_rd_addr                       (ex_rd_addr),
    .ex_reg_write                     (ex_reg_write),
    .ex_result                        (ex_result),
`endif
    .out_valid                        (out_valid),
    .out_ready                        (out_ready),
    .operation_add                    (op_add),
    .operation_subtract               (op_sub),
    .operation_and                    (op_and),
    .operation_or                     (op_or),
    .operation_xor                    (op_xor),
    .operation_shift_left_logical     (op_sll),
    .operation_shift_right_arithmetic (op_sra),
    .operation_shift_right_logical    (op_srl),
    .operand_1                        (operand_1),
    .operand_2                        (operand_2),
    .rd_addr                          (rd_addr),
    .reg_write                        (reg_write),
    .illegal_instruction              (illegal_instruction)
  );

  assign actual = {op_add, op_sub, op_and, op_or, op_xor, op_sll, op_sra, op_srl,
                   operand_1, operand_2, rd_addr, reg_write, illegal_instruction};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic exp_t mkExp(input logic [7:0] ops, input logic [31:0] op1,
                                 input logic [31:0] op2, input logic [4:0] rd);
    return {ops, op1, op2, rd, (rd != 5'd0), 1'b0};
  endfunction

  function automatic exp_t mkIll(input logic [4:0] rd);
    return {8'h00, 32'h0, 32'h0, rd, 1'b0, 1'b1};
  endfunction

  function automatic vec_t mkVec(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input exp_t e);
    return {instr, rs1, rs2, e};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on emit; reset/flush kill everything in flight.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        emitted++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0h, expected no entry", actual);
        end else begin
          mon_exp = sb.pop_front();
          mon_act = actual;
          if (mon_exp.ill) mon_act.rd = mon_exp.rd;
          checkOutput("emit_entry", 128'(mon_act), 128'(mon_exp));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic driveInputs(input vec_t v);
    instruction = v.instr;
    rs1_data    = v.rs1;
    rs2_data    = v.rs2;
    cur_exp     = v.exp;
    in_valid    = 1'b1;
  endtask

  task automatic waitAccept(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept_timeout: in_ready got 0, expected 1", name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    driveInputs(v);
    waitAccept(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_drained"}, 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int start_cyc;
    int start_emit;

    vecs[0]  = mkVec(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd8, 32'hFFFFFFF0, mkExp(F_ADD, 32'd8, 32'hFFFFFFF0, 5'd3));
    vecs[1]  = mkVec(rType(7'h20, 5'd6, 5'd5, 3'b000, 5'd4), 32'd100, 32'd3, mkExp(F_SUB, 32'd100, 32'd3, 5'd4));
    vecs[2]  = mkVec(rType(7'h00, 5'd9, 5'd8, 3'b111, 5'd7), 32'h0000F0F0, 32'h000000FF, mkExp(F_AND, 32'h0000F0F0, 32'h000000FF, 5'd7));
    vecs[3]  = mkVec(rType(7'h00, 5'd12, 5'd11, 3'b110, 5'd10), 32'h12340000, 32'h00005678, mkExp(F_OR, 32'h12340000, 32'h00005678, 5'd10));
    vecs[4]  = mkVec(rType(7'h00, 5'd14, 5'd15, 3'b100, 5'd13), 32'hAAAA5555, 32'hFFFF0000, mkExp(F_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd13));
    vecs[5]  = mkVec(rType(7'h00, 5'd2, 5'd1, 3'b001, 5'd16), 32'd1, 32'd5, mkExp(F_SLL, 32'd1, 32'd5, 5'd16));
    vecs[6]  = mkVec(rType(7'h00, 5'd2, 5'd1, 3'b101, 5'd17), 32'h80000000, 32'd3, mkExp(F_SRL, 32'h80000000, 32'd3, 5'd17));
    vecs[7]  = mkVec(rType(7'h20, 5'd2, 5'd1, 3'b101, 5'd18), 32'h80000000, 32'd3, mkExp(F_SRA, 32'h80000000, 32'd3, 5'd18));
    vecs[8]  = mkVec(iType(12'hFF0, 5'd1, 3'b000, 5'd5), 32'd8, 32'hDEADBEEF, mkExp(F_ADD, 32'd8, 32'hFFFFFFF0, 5'd5));
    vecs[9]  = mkVec(iType({7'h20, 5'd4}, 5'd1, 3'b101, 5'd6), 32'hFFFFFFC0, 32'h11111111, mkExp(F_SRA, 32'hFFFFFFC0, 32'd4, 5'd6));
    vecs[10] = mkVec(iType({7'h00, 5'd31}, 5'd2, 3'b001, 5'd7), 32'd3, 32'h22222222, mkExp(F_SLL, 32'd3, 32'd31, 5'd7));
    vecs[11] = mkVec(iType({7'h00, 5'd7}, 5'd3, 3'b101, 5'd8), 32'hFFFFFFFF, 32'h0, mkExp(F_SRL, 32'hFFFFFFFF, 32'd7, 5'd8));
    vecs[12] = mkVec(iType(12'h7FF, 5'd1, 3'b111, 5'd9), 32'h0F0F0F0F, 32'h0, mkExp(F_AND, 32'h0F0F0F0F, 32'h000007FF, 5'd9));
    vecs[13] = mkVec(iType(12'h800, 5'd1, 3'b110, 5'd10), 32'h00000001, 32'h0, mkExp(F_OR, 32'h00000001, 32'hFFFFF800, 5'd10));
    vecs[14] = mkVec(iType(12'hFFF, 5'd1, 3'b100, 5'd11), 32'h00000055, 32'h0, mkExp(F_XOR, 32'h00000055, 32'hFFFFFFFF, 5'd11));
    vecs[15] = mkVec(rType(7'h00, 5'd3, 5'd2, 3'b010, 5'd1), 32'd9, 32'd9, mkIll(5'd1));
    vecs[16] = mkVec(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd6, mkExp(F_ADD, 32'd5, 32'd6, 5'd0));
    vecs[17] = mkVec({20'h12345, 5'd5, 7'b0110111}, 32'd1, 32'd2, mkIll(5'd5));
    vecs[18] = mkVec(rType(7'h20, 5'd2, 5'd1, 3'b111, 5'd4), 32'd1, 32'd2, mkIll(5'd4));
    vecs[19] = mkVec(iType({7'h20, 5'd3}, 5'd1, 3'b001, 5'd4), 32'd1, 32'd2, mkIll(5'd4));
    vecs[20] = mkVec(iType(12'h005, 5'd1, 3'b010, 5'd4), 32'd1, 32'd2, mkIll(5'd4));
    vecs[21] = mkVec(rType(7'h00, 5'd2, 5'd1, 3'b011, 5'd9), 32'd1, 32'd2, mkIll(5'd9));
    vecs[22] = mkVec(rType(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), 32'd1, 32'd2, mkIll(5'd9));
    vecs[23] = mkVec(iType({7'h01, 5'd2}, 5'd1, 3'b101, 5'd9), 32'd1, 32'd2, mkIll(5'd9));

    // Reset with a valid instruction presented; it must be ignored.
    rst         = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b1;
    cur_exp     = vecs[0].exp;
    instruction = vecs[0].instr;
    rs1_data    = vecs[0].rs1;
    rs2_data    = vecs[0].rs2;
    in_valid    = 1'b1;
`ifdef ALU_ISSUE_FORWARD_EN
    ex_rd_addr   = 5'd0;
    ex_reg_write = 1'b0;
    ex_result    = 32'h0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_fields", 128'(actual), 128'(0));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_out_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;

    // Single add: one-cycle latency into an empty stage.
    applyStimulus(vecs[0], "latency");
    @(negedge clk);
    checkOutput("latency_out_valid", 128'(out_valid), 128'(1));
    checkOutput("latency_fields", 128'(actual), 128'(vecs[0].exp));
    @(posedge clk);
    #1;
    drain("latency");

    // Table sweep back-to-back at full rate.
    start_cyc = cycles;
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], "table");
    checkOutput("throughput_cycles", 128'(cycles - start_cyc), 128'(NVEC));
    drain("table");

    // Back-pressure: two accepts fill the buffer, the third waits.
    out_ready  = 1'b0;
    start_emit = emitted;
    applyStimulus(vecs[1], "bp_a");
    applyStimulus(vecs[2], "bp_b");
    driveInputs(vecs[3]);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", 128'(in_ready), 128'(0));
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_hold_fields", 128'(actual), 128'(vecs[1].exp));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitAccept("bp_c");
    drain("bp");
    checkOutput("bp_emit_count", 128'(emitted - start_emit), 128'(3));

    // Flush in MAIN with a live input handshake: both entries dropped.
    out_ready  = 1'b0;
    start_emit = emitted;
    applyStimulus(vecs[4], "flush_main_a");
    driveInputs(vecs[5]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_main_out_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_main_in_ready", 128'(in_ready), 128'(1));

    // Flush in SKID with in_valid high.
    @(posedge clk);
    #1;
    applyStimulus(vecs[6], "flush_skid_a");
    applyStimulus(vecs[7], "flush_skid_b");
    driveInputs(vecs[8]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_skid_out_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_skid_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flush_no_output", 128'(emitted - start_emit), 128'(0));
    applyStimulus(vecs[9], "post_flush");
    drain("post_flush");

    // Reset while the buffer is full.
    out_ready  = 1'b0;
    applyStimulus(vecs[10], "rst_mid_a");
    applyStimulus(vecs[11], "rst_mid_b");
    start_emit = emitted;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_mid_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_mid_fields", 128'(actual), 128'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_output", 128'(emitted - start_emit), 128'(0));

`ifdef ALU_ISSUE_FORWARD_EN
    ex_rd_addr   = 5'd1;
    ex_reg_write = 1'b1;
    ex_result    = 32'd32;
    applyStimulus(mkVec(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd7, 32'd5,
                        mkExp(F_ADD, 32'd32, 32'd5, 5'd3)), "fwd_rs1");
    applyStimulus(mkVec(rType(7'h00, 5'd1, 5'd4, 3'b000, 5'd3), 32'd7, 32'd5,
                        mkExp(F_ADD, 32'd7, 32'd32, 5'd3)), "fwd_rs2");
    applyStimulus(mkVec(iType(12'h001, 5'd2, 3'b000, 5'd3), 32'd7, 32'd5,
                        mkExp(F_ADD, 32'd7, 32'd1, 5'd3)), "fwd_itype_no_rs2");
    ex_rd_addr = 5'd0;
    applyStimulus(mkVec(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd7, 32'd5,
                        mkExp(F_ADD, 32'd7, 32'd5, 5'd3)), "fwd_x0");
    ex_reg_write = 1'b0;
    drain("fwd");
`endif

    checkOutput("final_queue_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
